// File: rtl/seg7_bus_decoder.sv
// Receive-side 7-segment pattern decoder: waits for a pattern to settle,
// decodes it to a hex digit, and flags and counts illegal patterns.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   enable         1: decoder runs; 0: forced to IDLE
//   seg_in[6:0]    segment pattern, bit0=a .. bit6=g
//   digit[3:0]     last successfully decoded hex digit
//   digit_valid    locked on a legal non-blank pattern
//   blank          locked on the all-off pattern
//   pattern_err    stable pattern is not a legal glyph
//   change_pulse   one-cycle strobe when digit takes a new value
//   err_count      saturating count of FAULT entries
module seg7_bus_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter bit ACTIVE_LOW    = 1'b0,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [6:0]       seg_in,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             blank,
    output logic             pattern_err,
    output logic             change_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        LOCKED,
        FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       seg_q, seg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       digit_q, digit_d;
    logic             valid_q, valid_d;
    logic             blank_q, blank_d;
    logic             perr_q, perr_d;
    logic             pulse_q, pulse_d;
    logic             seen_q, seen_d;
    logic [CNT_W-1:0] err_q, err_d;

    logic [6:0] p;
    logic       is_legal;
    logic       is_blank;
    logic [3:0] dec_val;

    assign p = ACTIVE_LOW ? ~seg_in : seg_in;

    always_comb begin
        is_legal = 1'b1;
        is_blank = 1'b0;
        dec_val  = 4'h0;
        case (p)
            7'h3F: dec_val = 4'h0;
            7'h06: dec_val = 4'h1;
            7'h5B: dec_val = 4'h2;
            7'h4F: dec_val = 4'h3;
            7'h66: dec_val = 4'h4;
            7'h6D: dec_val = 4'h5;
            7'h7D: dec_val = 4'h6;
            7'h07: dec_val = 4'h7;
            7'h7F: dec_val = 4'h8;
            7'h6F: dec_val = 4'h9;
            7'h77: dec_val = 4'hA;
            7'h7C: dec_val = 4'hB;
            7'h39: dec_val = 4'hC;
            7'h5E: dec_val = 4'hD;
            7'h79: dec_val = 4'hE;
            7'h71: dec_val = 4'hF;
            7'h00: begin
                is_legal = 1'b0;
                is_blank = 1'b1;
            end
            default: is_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        cnt_d   = cnt_q;
        digit_d = digit_q;
        valid_d = valid_q;
        blank_d = blank_q;
        perr_d  = perr_q;
        pulse_d = 1'b0;
        seen_d  = seen_q;
        err_d   = err_q;

        if (!enable) begin
            state_d = IDLE;
            valid_d = 1'b0;
            blank_d = 1'b0;
            perr_d  = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = SETTLE;
            seg_d   = p;
            cnt_d   = '0;
            valid_d = 1'b0;
            blank_d = 1'b0;
            perr_d  = 1'b0;
        end else if (p != seg_q) begin
            // Any change restarts settling and drops the current verdict.
            state_d = SETTLE;
            seg_d   = p;
            cnt_d   = '0;
            valid_d = 1'b0;
            blank_d = 1'b0;
            perr_d  = 1'b0;
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            // Only SETTLE decodes, so a steady FAULT counts once.
            if (state_q == SETTLE && cnt_q == CNT_MAX) begin
                if (is_blank) begin
                    state_d = LOCKED;
                    blank_d = 1'b1;
                end else if (is_legal) begin
                    state_d = LOCKED;
                    valid_d = 1'b1;
                    digit_d = dec_val;
                    pulse_d = !seen_q || (dec_val != digit_q);
                    seen_d  = 1'b1;
                end else begin
                    state_d = FAULT;
                    perr_d  = 1'b1;
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            seg_q   <= '0;
            cnt_q   <= '0;
            digit_q <= '0;
            valid_q <= 1'b0;
            blank_q <= 1'b0;
            perr_q  <= 1'b0;
            pulse_q <= 1'b0;
            seen_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            valid_q <= valid_d;
            blank_q <= blank_d;
            perr_q  <= perr_d;
            pulse_q <= pulse_d;
            seen_q  <= seen_d;
            err_q   <= err_d;
        end
    end

    assign digit        = digit_q;
    assign digit_valid  = valid_q;
    assign blank        = blank_q;
    assign pattern_err  = perr_q;
    assign change_pulse = pulse_q;
    assign err_count    = err_q;

endmodule

// File: tb/tb_seg7_bus_decoder.sv
// Scoreboard bench for seg7_bus_decoder: three configurations driven with
// the same logical pattern stream, checked against a run-length model.
module tb_seg7_bus_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [6:0] seg_p = 7'h00;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    logic [3:0] dg [3];
    logic       dv [3];
    logic       bl [3];
    logic       pe [3];
    logic       cp [3];
    logic [7:0] ec0;
    logic [1:0] ec1;
    logic [2:0] ec2;

    seg7_bus_decoder #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b0), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .enable(en), .seg_in(seg_p),
        .digit(dg[0]), .digit_valid(dv[0]), .blank(bl[0]),
        .pattern_err(pe[0]), .change_pulse(cp[0]), .err_count(ec0)
    );

    seg7_bus_decoder #(.STABLE_CYCLES(2), .ACTIVE_LOW(1'b1), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .enable(en), .seg_in(~seg_p),
        .digit(dg[1]), .digit_valid(dv[1]), .blank(bl[1]),
        .pattern_err(pe[1]), .change_pulse(cp[1]), .err_count(ec1)
    );

    seg7_bus_decoder #(.STABLE_CYCLES(1), .ACTIVE_LOW(1'b0), .CNT_W(3)) u2 (
        .clk(clk), .rst(rst), .enable(en), .seg_in(seg_p),
        .digit(dg[2]), .digit_valid(dv[2]), .blank(bl[2]),
        .pattern_err(pe[2]), .change_pulse(cp[2]), .err_count(ec2)
    );

    function automatic int sc_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 2 : 1;
    endfunction

    function automatic int emax_of(input int k);
        return (k == 0) ? 255 : (k == 1) ? 3 : 7;
    endfunction

    // Glyph table indexed by hex value.
    logic [6:0] glyph [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Reference model: "run" is how many edges the captured pattern has
    // stayed unchanged; the verdict is taken when run reaches STABLE_CYCLES.
    bit         m_idle [3];
    logic [6:0] m_cap  [3];
    int         m_run  [3];
    int         m_dig  [3];
    int         m_err  [3];
    bit         m_v [3];
    bit         m_b [3];
    bit         m_e [3];
    bit         m_p [3];
    bit         m_seen [3];

    logic [47:0] sb [$];

    function automatic logic [15:0] pack_exp(input int k);
        logic [3:0] d4;
        logic [7:0] e8;
        d4 = m_dig[k][3:0];
        e8 = m_err[k][7:0];
        return {d4, m_v[k], m_b[k], m_e[k], m_p[k], e8};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_idle[k] = 1'b1;
            m_cap[k]  = 7'h00;
            m_run[k]  = 0;
            m_dig[k]  = 0;
            m_err[k]  = 0;
            m_v[k]    = 1'b0;
            m_b[k]    = 1'b0;
            m_e[k]    = 1'b0;
            m_p[k]    = 1'b0;
            m_seen[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input bit e, input logic [6:0] p);
        int idx;
        m_p[k] = 1'b0;
        if (!e) begin
            m_idle[k] = 1'b1;
            m_v[k] = 1'b0;
            m_b[k] = 1'b0;
            m_e[k] = 1'b0;
        end else if (m_idle[k] || p != m_cap[k]) begin
            m_idle[k] = 1'b0;
            m_cap[k] = p;
            m_run[k] = 0;
            m_v[k] = 1'b0;
            m_b[k] = 1'b0;
            m_e[k] = 1'b0;
        end else begin
            m_run[k]++;
            if (m_run[k] == sc_of(k)) begin
                idx = -1;
                for (int i = 0; i < 16; i++)
                    if (glyph[i] == p) idx = i;
                if (p == 7'h00) begin
                    m_b[k] = 1'b1;
                end else if (idx >= 0) begin
                    m_v[k] = 1'b1;
                    m_p[k] = !m_seen[k] || (idx != m_dig[k]);
                    m_dig[k] = idx;
                    m_seen[k] = 1'b1;
                end else begin
                    m_e[k] = 1'b1;
                    if (m_err[k] < emax_of(k)) m_err[k]++;
                end
            end
        end
    endtask

    function automatic logic [47:0] pack_all();
        return {pack_exp(2), pack_exp(1), pack_exp(0)};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
            sb.delete();
            sb.push_back(pack_all());
        end else begin
            for (int k = 0; k < 3; k++) model_step(k, en, seg_p);
            sb.push_back(pack_all());
        end
    end

    logic [47:0] act;
    always_comb begin
        act[15:0]  = {dg[0], dv[0], bl[0], pe[0], cp[0], ec0};
        act[31:16] = {dg[1], dv[1], bl[1], pe[1], cp[1], 6'd0, ec1};
        act[47:32] = {dg[2], dv[2], bl[2], pe[2], cp[2], 5'd0, ec2};
    end

    always @(negedge clk) begin
        logic [47:0] exp_v;
        logic [15:0] a;
        logic [15:0] x;
        if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            for (int k = 0; k < 3; k++) begin
                a = act[k*16 +: 16];
                x = exp_v[k*16 +: 16];
                checks++;
                if (a !== x) begin
                    failures++;
                    $display("FAIL dut%0d t=%0t got dig=%h v=%b b=%b e=%b p=%b err=%0d want dig=%h v=%b b=%b e=%b p=%b err=%0d",
                             k, $time, a[15:12], a[11], a[10], a[9], a[8], a[7:0],
                             x[15:12], x[11], x[10], x[9], x[8], x[7:0]);
                end
            end
        end
    end

    task automatic drive(input logic [6:0] pat, input bit e, input int n);
        seg_p = pat;
        en = e;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        int r;
        logic [6:0] pat;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(7'h00, 1'b0, 2);
        // Lock on 3 and hold, then a one-cycle glitch.
        drive(7'h4F, 1'b1, 25);
        drive(7'h4E, 1'b1, 1);
        drive(7'h4F, 1'b1, 10);
        drive(7'h06, 1'b1, 8);
        // Steady illegal, then alternating illegals for saturation.
        drive(7'h01, 1'b1, 10);
        for (int i = 0; i < 6; i++)
            drive((i % 2) ? 7'h02 : 7'h01, 1'b1, 6);
        // Blank keeps digit; then digit 0.
        drive(7'h00, 1'b1, 8);
        drive(7'h3F, 1'b1, 8);
        drive(7'h00, 1'b1, 8);
        // Enable drop while locked, then relock.
        drive(7'h3F, 1'b0, 3);
        drive(7'h3F, 1'b1, 8);
        // Reset mid-settle and mid-lock.
        drive(7'h5B, 1'b1, 2);
        pulse_reset(2);
        drive(7'h5B, 1'b1, 8);
        pulse_reset(1);
        drive(7'h5B, 1'b1, 8);
        // Randomized traffic.
        for (int it = 0; it < 600; it++) begin
            r = $urandom_range(0, 19);
            if (r < 11)      pat = glyph[$urandom_range(0, 15)];
            else if (r < 13) pat = 7'h00;
            else             pat = 7'($urandom_range(0, 127));
            if (r == 19)
                pulse_reset($urandom_range(1, 2));
            else if (r == 18)
                drive(pat, 1'b0, $urandom_range(1, 3));
            else if (r == 17)
                drive(pat, 1'b1, 1);
            else
                drive(pat, 1'b1, $urandom_range(1, 8));
        end
        drive(7'h7F, 1'b1, 8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
